// File: rtl/clk_div_sched_if.sv
// Divide-ratio configuration channel for clk_div_sched: valid/ready offer plus
// a one-cycle error pulse for rejected ratios.
interface clk_div_sched_if #(
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (output cfg_valid, output cfg_div, input cfg_ready, input cfg_err);
  modport slave  (input cfg_valid, input cfg_div, output cfg_ready, output cfg_err);
endinterface

// File: rtl/clk_div_sched.sv
// Clock-enable divider: emits a one-cycle strobe and a phase level every cur_div
// cycles, with ratio changes and start/stop taking effect only on period boundaries.
module clk_div_sched #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4,
  parameter int PCNT_W      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  clk_div_sched_if.slave    cfg,
  output logic              div_clk_en,
  output logic              div_phase,
  output logic [PCNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0]  cur_div,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_e;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  DIV_MIN  = CNT_W'(2);
  localparam logic [CNT_W-1:0]  DIV_RST  = CNT_W'(DEFAULT_DIV);
  localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cur_div_q, cur_div_d;
  logic [CNT_W-1:0]    pend_div_q, pend_div_d;
  logic                pend_q, pend_d;
  logic                err_q, err_d;
  logic                en_q, en_d;
  logic                phase_q, phase_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic                boundary;
  logic                accept;
  logic                apply;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pend_d     = pend_q;
    err_d      = 1'b0;
    en_d       = 1'b0;
    pcnt_d     = pcnt_q;

    accept   = cfg.cfg_valid && !pend_q;
    boundary = (state_q != IDLE) && (cnt_q == cur_div_q - CNT_ONE);
    apply    = pend_q && ((state_q == IDLE) || boundary);

    // A pending ratio is never accepted and applied on the same edge: ready is low while pending.
    if (apply) begin
      cur_div_d = pend_div_q;
      pend_d    = 1'b0;
    end
    if (accept) begin
      if (cfg.cfg_div < DIV_MIN) begin
        err_d = 1'b1;
      end else begin
        pend_d     = 1'b1;
        pend_div_d = cfg.cfg_div;
      end
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (run) begin
          state_d = RUN;
          en_d    = 1'b1;
          pcnt_d  = pcnt_q + PCNT_ONE;
        end
      end
      default: begin
        if (boundary) begin
          cnt_d = '0;
          if (run) begin
            state_d = RUN;
            en_d    = 1'b1;
            pcnt_d  = pcnt_q + PCNT_ONE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = run ? RUN : STOP_PEND;
        end
      end
    endcase

    // Phase is computed from next-state values so it lines up with the registered cnt.
    phase_d = (state_d != IDLE) && (cnt_d < (cur_div_d >> 1));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_div_q  <= DIV_RST;
      // NOTE: the pending ratio is reset too, so a stale value can never leak into cur_div.
      pend_div_q <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      en_q       <= 1'b0;
      phase_q    <= 1'b0;
      pcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      en_q       <= en_d;
      phase_q    <= phase_d;
      pcnt_q     <= pcnt_d;
    end
  end

  assign cfg.cfg_ready = !pend_q;
  assign cfg.cfg_err   = err_q;
  assign div_clk_en    = en_q;
  assign div_phase     = phase_q;
  assign period_cnt    = pcnt_q;
  assign cur_div       = cur_div_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: expected strobes (cycle, period count,
// ratio) are queued as stimulus is driven and matched when the DUT strobes.
module tb_clk_div_sched;

  typedef struct {
    int         cyc;
    logic [1:0] pc;
    logic [7:0] div;
  } strobe_t;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       div_clk_en;
  logic       div_phase;
  logic [1:0] period_cnt;
  logic [7:0] cur_div;
  logic       busy;

  int         cyc;
  int         checks;
  int         errors;
  logic [1:0] pc_exp;
  strobe_t    sb_q[$];

  clk_div_sched_if #(.CNT_W(8)) cfg_if ();

  clk_div_sched #(.CNT_W(8), .DEFAULT_DIV(4), .PCNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .cfg        (cfg_if),
    .div_clk_en (div_clk_en),
    .div_phase  (div_phase),
    .period_cnt (period_cnt),
    .cur_div    (cur_div),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    strobe_t e;
    if (div_clk_en === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: strobe at cycle %0d, expected none", cyc);
      end else begin
        e = sb_q.pop_front();
        if (cyc !== e.cyc || period_cnt !== e.pc || cur_div !== e.div) begin
          errors++;
          $display("FAIL strobe: got cyc=%0d pcnt=%0d div=%0d, expected cyc=%0d pcnt=%0d div=%0d",
                   cyc, period_cnt, cur_div, e.cyc, e.pc, e.div);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_strobe(input int at_cyc, input logic [7:0] div);
    strobe_t e;
    pc_exp = pc_exp + 2'd1;
    e.cyc = at_cyc;
    e.pc  = pc_exp;
    e.div = div;
    sb_q.push_back(e);
  endtask

  task automatic drain_check(input string name);
    checks++;
    if (sb_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_missing_strobes: %0d expected strobes never seen, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic set_div_idle(input logic [7:0] div);
    cfg_if.cfg_div   = div;
    cfg_if.cfg_valid = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0;
    step();
    checks++;
    if (cur_div !== div) begin
      errors++;
      $display("FAIL set_div_idle: cur_div got %0d expected %0d", cur_div, div);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_if.cfg_ready); end
    checks++;
    if (cfg_if.cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_if.cfg_err); end
    checks++;
    if (div_clk_en !== 1'b0) begin errors++; $display("FAIL reset_div_clk_en: got %b expected 0", div_clk_en); end
    checks++;
    if (div_phase !== 1'b0) begin errors++; $display("FAIL reset_div_phase: got %b expected 0", div_phase); end
    checks++;
    if (period_cnt !== 2'd0) begin errors++; $display("FAIL reset_period_cnt: got %0d expected 0", period_cnt); end
    checks++;
    if (cur_div !== 8'd4) begin errors++; $display("FAIL reset_cur_div: got %0d expected 4", cur_div); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_default_run();
    int   c0 = cyc;
    logic exp;
    for (int i = 0; i < 5; i++) push_strobe(c0 + 1 + 4 * i, 8'd4);
    run = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k <= 8) begin
        exp = ((k - 1) % 4) < 2;
        checks++;
        if (div_phase !== exp) begin errors++; $display("FAIL div4_phase k=%0d: got %b expected %b", k, div_phase, exp); end
      end
      if (k == 17) run = 1'b0;
      if (k == 20) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL div4_stop_pending_busy: got %b expected 1", busy); end
      end
    end
    checks++;
    if (busy !== 1'b0 || div_phase !== 1'b0) begin
      errors++;
      $display("FAIL div4_idle: busy=%b phase=%b expected 0 0", busy, div_phase);
    end
    drain_check("div4");
  endtask

  task automatic test_reconfig_running();
    int   c0 = cyc;
    logic exp;
    push_strobe(c0 + 1, 8'd4);
    push_strobe(c0 + 5, 8'd6);
    push_strobe(c0 + 11, 8'd6);
    push_strobe(c0 + 17, 8'd6);
    run = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 2) begin
        cfg_if.cfg_div   = 8'd6;
        cfg_if.cfg_valid = 1'b1;
      end
      if (k == 3) cfg_if.cfg_valid = 1'b0;
      if (k >= 3 && k <= 5) begin
        checks++;
        if (cfg_if.cfg_ready !== (k == 5)) begin
          errors++;
          $display("FAIL reconfig_ready k=%0d: got %b expected %b", k, cfg_if.cfg_ready, (k == 5));
        end
      end
      if (k >= 5 && k <= 10) begin
        exp = (k - 5) < 3;
        checks++;
        if (div_phase !== exp) begin errors++; $display("FAIL div6_phase k=%0d: got %b expected %b", k, div_phase, exp); end
      end
      if (k == 17) run = 1'b0;
      if (k == 22) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL div6_stop_pending_busy: got %b expected 1", busy); end
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL div6_idle_busy: got %b expected 0", busy); end
    drain_check("reconfig");
  endtask

  task automatic test_cfg_idle();
    logic [7:0] bad [2] = '{8'd1, 8'd0};
    for (int i = 0; i < 2; i++) begin
      cfg_if.cfg_div   = bad[i];
      cfg_if.cfg_valid = 1'b1;
      step();
      cfg_if.cfg_valid = 1'b0;
      checks++;
      if (cfg_if.cfg_err !== 1'b1 || cfg_if.cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL cfg_err_pulse div=%0d: err=%b ready=%b expected 1 1", bad[i], cfg_if.cfg_err, cfg_if.cfg_ready);
      end
      step();
      checks++;
      if (cfg_if.cfg_err !== 1'b0 || cur_div !== 8'd6) begin
        errors++;
        $display("FAIL cfg_err_after div=%0d: err=%b cur_div=%0d expected 0 6", bad[i], cfg_if.cfg_err, cur_div);
      end
    end
    cfg_if.cfg_div   = 8'd5;
    cfg_if.cfg_valid = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0;
    checks++;
    if (cfg_if.cfg_ready !== 1'b0 || cur_div !== 8'd6) begin
      errors++;
      $display("FAIL idle_cfg_pending: ready=%b cur_div=%0d expected 0 6", cfg_if.cfg_ready, cur_div);
    end
    step();
    checks++;
    if (cfg_if.cfg_ready !== 1'b1 || cur_div !== 8'd5) begin
      errors++;
      $display("FAIL idle_cfg_apply: ready=%b cur_div=%0d expected 1 5", cfg_if.cfg_ready, cur_div);
    end
  endtask

  task automatic test_stop();
    int c0 = cyc;
    push_strobe(c0 + 1, 8'd5);
    push_strobe(c0 + 6, 8'd5);
    run = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 7) run = 1'b0;
      if (k == 10 || k == 11) begin
        checks++;
        if (busy !== (k == 10)) begin errors++; $display("FAIL stop_busy k=%0d: got %b expected %b", k, busy, (k == 10)); end
      end
    end
    checks++;
    if (div_phase !== 1'b0) begin errors++; $display("FAIL stop_phase: got %b expected 0", div_phase); end
    drain_check("stop");
  endtask

  task automatic test_back_to_back_rerun();
    int c0 = cyc;
    for (int i = 0; i < 4; i++) push_strobe(c0 + 1 + 5 * i, 8'd5);
    run = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k == 7) run = 1'b0;
      if (k == 9) run = 1'b1;
      if (k == 16) run = 1'b0;
      if (k == 20 || k == 21) begin
        checks++;
        if (busy !== (k == 20)) begin errors++; $display("FAIL rerun_busy k=%0d: got %b expected %b", k, busy, (k == 20)); end
      end
    end
    drain_check("rerun");
  endtask

  task automatic test_boundary_cfg();
    int   c0;
    logic exp;
    set_div_idle(8'd2);
    c0 = cyc;
    push_strobe(c0 + 1, 8'd2);
    push_strobe(c0 + 3, 8'd2);
    push_strobe(c0 + 5, 8'd3);
    push_strobe(c0 + 8, 8'd3);
    push_strobe(c0 + 11, 8'd3);
    run = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 2) begin
        cfg_if.cfg_div   = 8'd3;
        cfg_if.cfg_valid = 1'b1;
      end
      if (k == 3) cfg_if.cfg_valid = 1'b0;
      if (k >= 3 && k <= 5) begin
        checks++;
        if (cfg_if.cfg_ready !== (k == 5)) begin
          errors++;
          $display("FAIL boundary_ready k=%0d: got %b expected %b", k, cfg_if.cfg_ready, (k == 5));
        end
      end
      if (k <= 2 || (k >= 5 && k <= 7)) begin
        exp = (k == 1) || (k == 5);
        checks++;
        if (div_phase !== exp) begin errors++; $display("FAIL boundary_phase k=%0d: got %b expected %b", k, div_phase, exp); end
      end
      if (k == 11) run = 1'b0;
      if (k == 13 || k == 14) begin
        checks++;
        if (busy !== (k == 13)) begin errors++; $display("FAIL boundary_busy k=%0d: got %b expected %b", k, busy, (k == 13)); end
      end
    end
    drain_check("boundary");
  endtask

  task automatic test_reset_mid();
    int c0;
    set_div_idle(8'd6);
    c0 = cyc;
    push_strobe(c0 + 1, 8'd6);
    run = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 1) begin
        cfg_if.cfg_div   = 8'd5;
        cfg_if.cfg_valid = 1'b1;
      end
      if (k == 2) begin
        cfg_if.cfg_valid = 1'b0;
        checks++;
        if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_pending_ready: got %b expected 0", cfg_if.cfg_ready); end
      end
    end
    rst_n            = 1'b0;
    cfg_if.cfg_div   = 8'd7;
    cfg_if.cfg_valid = 1'b1;
    step();
    checks++;
    if ({cfg_if.cfg_ready, cfg_if.cfg_err, div_clk_en, div_phase, period_cnt, cur_div, busy}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd4, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: ready=%b err=%b en=%b phase=%b pcnt=%0d div=%0d busy=%b expected 1 0 0 0 0 4 0",
               cfg_if.cfg_ready, cfg_if.cfg_err, div_clk_en, div_phase, period_cnt, cur_div, busy);
    end
    rst_n            = 1'b1;
    run              = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    pc_exp           = 2'd0;
    for (int k = 1; k <= 2; k++) begin
      step();
      checks++;
      if (cur_div !== 8'd4 || cfg_if.cfg_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_discard k=%0d: div=%0d ready=%b busy=%b expected 4 1 0", k, cur_div, cfg_if.cfg_ready, busy);
      end
    end
    drain_check("reset_mid");
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    pc_exp           = 2'd0;
    rst_n            = 1'b0;
    run              = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = 8'd0;
    step();
    step();
    rst_n = 1'b1;
    test_reset();
    test_default_run();
    test_reconfig_running();
    test_cfg_idle();
    test_stop();
    test_back_to_back_rerun();
    test_boundary_cfg();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
